digdug_hvgen: RTL and testbench
===============================

// Module: digdug_hvgen
// PURPOSE
//  Video timing generator and pixel output stage around the DigDug core.
//  Upstream: derives 6 MHz pixel enable from 48 MHz MCLK and drives PH/PV into the core.
//  Downstream: registers the core's POUT, applies blanking, and emits aligned sync/blank for the scan converter.
// PARAMETERS
//  CLKDIV   8    MCLK cycles per pixel (>=2)
//  HTOTAL   384  pixels per line
//  HVIS     288  visible pixels per line (PH 0..HVIS-1)
//  HS_START 304  PH at which HSYN asserts
//  HS_WIDTH 32   HSYN width, pixels
//  VTOTAL   264  lines per frame
//  VVIS     224  visible lines (PV 0..VVIS-1)
//  VS_START 240  PV at which VSYN asserts
//  VS_WIDTH 8    VSYN width, lines
// PORTS
//  MCLK     in   1  master clock 48 MHz
//  RESET    in   1  synchronous reset, active-high
//  HOFS     in   4  signed H sync shift, pixels (SYNC_SHIFT_EN only)
//  VOFS     in   4  signed V sync shift, lines (SYNC_SHIFT_EN only)
//  POUT     in   8  pixel from core, RRRGGGBB, valid for current PH/PV
//  PCLK_EN  out  1  one-MCLK pulse per pixel
//  PH       out  9  horizontal pixel counter to core
//  PV       out  9  vertical line counter to core
//  HBLK     out  1  PH >= HVIS (aligned with PH)
//  VBLK     out  1  PV >= VVIS (aligned with PV)
//  FRAME    out  1  one-MCLK pulse when PV wraps to 0
//  VID_RGB  out  8  registered pixel, 0 when blanked
//  VID_HB   out  1  HBLK delayed one pixel (aligned with VID_RGB)
//  VID_VB   out  1  VBLK delayed one pixel
//  VID_HS   out  1  HSYN, one pixel late, aligned with VID_RGB
//  VID_VS   out  1  VSYN, aligned with VID_RGB
// BEHAVIOUR
//  - Reset: div=0, PH=0, PV=0, PCLK_EN=0, HBLK=0, VBLK=0, FRAME=0, VID_RGB=0,
//    VID_HB=1, VID_VB=1, VID_HS=0, VID_VS=0. Reset mid-frame: next edge restarts at PH=PV=0.
//  - Divider counts 0..CLKDIV-1, wraps. PCLK_EN=1 on the cycle div==CLKDIV-1.
//  - PH/PV/HBLK/VBLK/FRAME update only on the PCLK_EN cycle; otherwise hold.
//    FRAME exception: high for exactly the one MCLK cycle (the PCLK_EN edge) where PV 263->0.
//  - PH: HTOTAL-1 -> 0, PV increments on the same edge; PV: VTOTAL-1 -> 0.
//  - HBLK/VBLK are computed from next counter values so they change with PH/PV, never a cycle late.
//  - Output stage, on PCLK_EN: VID_RGB <= (HBLK|VBLK) ? 0 : POUT (sampled for the PH/PV just ending);
//    VID_HB/VID_VB <= HBLK/VBLK; VID_HS <= (PH in [HSs, HSs+HS_WIDTH)); VID_VS likewise on PV.
//    Latency PH/PV -> VID_*: exactly one pixel (CLKDIV MCLK).
//  - Sync windows compare modulo HTOTAL/VTOTAL (window may straddle wrap); widths unchanged.
//  - All arithmetic on PH/PV is 9-bit unsigned; 10-bit intermediates for start+width/offset, then mod.
// CONFIGURATION
//  SYNC_SHIFT_EN defined: HSs = (HS_START + sext(HOFS)) mod HTOTAL, VSs = (VS_START + sext(VOFS)) mod VTOTAL;
//   HOFS/VOFS sampled only when FRAME fires (no mid-frame tearing); reset value of sampled offsets 0.
//  SYNC_SHIFT_EN undefined: HSs = HS_START, VSs = VS_START; HOFS/VOFS ignored (ports remain).
// TESTING
//  1. RESET 3 cycles, release -> PCLK_EN first at MCLK 8, then every 8; PH 0,1,2... on those edges.
//  2. Run one full line -> PH 383->0 with PV 0->1 same edge; HBLK rises at PH=288, falls at PH=0.
//  3. Run full frame -> FRAME one MCLK pulse at PV 263->0; VBLK high for PV 224..263; 101376 pixels/frame.
//  4. POUT=8'hA5 constant -> VID_RGB=A5 one pixel after PH=0..287, 00 at PH=288 (one pixel late), VID_HS high for 32 pixels starting one pixel after PH=304.
//  5. SYNC_SHIFT_EN, HOFS=-4 (4'hC), VOFS=+3 mid-frame -> no change until FRAME; next frame HSYN at PH=300, VSYN at PV=243..250.
//  6. RESET asserted at PH=150,PV=100 -> next edge PH=PV=0, VID_RGB=0, VID_HB=VID_VB=1, PCLK_EN restarts 8 cycles after release.

Source files
------------

// File: rtl/digdug_hvgen.sv
// digdug_hvgen
//   Video timing generator and pixel output stage for the DigDug core.
//   Divides MCLK down to a pixel enable, runs the PH/PV raster counters that
//   feed the core, and registers the core's pixel together with blanking and
//   sync so that all VID_* outputs share the same one-pixel latency.
//
//   Optional feature macro: SYNC_SHIFT_EN
//     defined   - sync windows are shifted by the signed HOFS/VOFS offsets,
//                 which are captured once per frame when FRAME fires.
//     undefined - sync windows start at HS_START/VS_START; HOFS/VOFS unused.
//
// Ports
//   MCLK     in   master clock (48 MHz)
//   RESET    in   synchronous reset, active high
//   HOFS     in   [3:0] signed horizontal sync shift, pixels
//   VOFS     in   [3:0] signed vertical sync shift, lines
//   POUT     in   [7:0] RRRGGGBB pixel from the core for the current PH/PV
//   PCLK_EN  out  one-MCLK pulse per pixel
//   PH       out  [8:0] horizontal pixel counter
//   PV       out  [8:0] vertical line counter
//   HBLK     out  horizontal blank, aligned with PH
//   VBLK     out  vertical blank, aligned with PV
//   FRAME    out  one-MCLK pulse when PV wraps to 0
//   VID_RGB  out  [7:0] registered pixel, zero while blanked
//   VID_HB   out  HBLK delayed one pixel
//   VID_VB   out  VBLK delayed one pixel
//   VID_HS   out  horizontal sync, aligned with VID_RGB
//   VID_VS   out  vertical sync, aligned with VID_RGB
module digdug_hvgen #(
    parameter int unsigned CLKDIV   = 8,
    parameter int unsigned HTOTAL   = 384,
    parameter int unsigned HVIS     = 288,
    parameter int unsigned HS_START = 304,
    parameter int unsigned HS_WIDTH = 32,
    parameter int unsigned VTOTAL   = 264,
    parameter int unsigned VVIS     = 224,
    parameter int unsigned VS_START = 240,
    parameter int unsigned VS_WIDTH = 8
) (
    input  logic       MCLK,
    input  logic       RESET,
    input  logic [3:0] HOFS,
    input  logic [3:0] VOFS,
    input  logic [7:0] POUT,
    output logic       PCLK_EN,
    output logic [8:0] PH,
    output logic [8:0] PV,
    output logic       HBLK,
    output logic       VBLK,
    output logic       FRAME,
    output logic [7:0] VID_RGB,
    output logic       VID_HB,
    output logic       VID_VB,
    output logic       VID_HS,
    output logic       VID_VS
);

    localparam int unsigned DW     = $clog2(CLKDIV);
    localparam logic [9:0]  HTOT10 = 10'(HTOTAL);
    localparam logic [9:0]  VTOT10 = 10'(VTOTAL);
    localparam logic [9:0]  HSW10  = 10'(HS_WIDTH);
    localparam logic [9:0]  VSW10  = 10'(VS_WIDTH);

    logic [DW-1:0] div;
    logic [8:0]    ph_next;
    logic [8:0]    pv_next;
    logic          frame_wrap;
    logic [8:0]    hs_start;
    logic [8:0]    vs_start;
    logic          hs_in;
    logic          vs_in;

    // Membership test for a sync window that may straddle the counter wrap:
    // distance from the window start, taken modulo total, must be < width.
    function automatic logic in_window(input logic [8:0] pos,
                                       input logic [8:0] start,
                                       input logic [9:0] width,
                                       input logic [9:0] total);
        logic [9:0] d;
        d = {1'b0, pos} + total - {1'b0, start};
        if (d >= total)
            d = d - total;
        return (d < width);
    endfunction

`ifdef SYNC_SHIFT_EN
    logic [3:0] hofs_q;
    logic [3:0] vofs_q;

    // (base + sext(ofs)) mod total; biased by total so the 10-bit sum never
    // goes negative, leaving at most two subtractions to bring it in range.
    function automatic logic [8:0] shift_mod(input logic [9:0] base,
                                             input logic [3:0] ofs,
                                             input logic [9:0] total);
        logic [9:0] v;
        logic [9:0] two_total;
        two_total = {total[8:0], 1'b0};
        v = base + total + {{6{ofs[3]}}, ofs};
        if (v >= two_total)
            v = v - two_total;
        else if (v >= total)
            v = v - total;
        return v[8:0];
    endfunction

    // Offsets change only at the frame boundary so a frame is never torn.
    always_ff @(posedge MCLK) begin
        if (RESET) begin
            hofs_q <= '0;
            vofs_q <= '0;
        end else if (FRAME) begin
            hofs_q <= HOFS;
            vofs_q <= VOFS;
        end
    end

    always_comb begin
        hs_start = shift_mod(10'(HS_START), hofs_q, HTOT10);
        vs_start = shift_mod(10'(VS_START), vofs_q, VTOT10);
    end
`else
    logic unused_ofs;
    assign unused_ofs = ^{HOFS, VOFS};

    always_comb begin
        hs_start = 9'(HS_START);
        vs_start = 9'(VS_START);
    end
`endif

    assign PCLK_EN = (div == DW'(CLKDIV - 1));

    always_comb begin
        ph_next    = PH + 9'd1;
        pv_next    = PV;
        frame_wrap = 1'b0;
        if (PH == 9'(HTOTAL - 1)) begin
            ph_next = '0;
            if (PV == 9'(VTOTAL - 1)) begin
                pv_next    = '0;
                frame_wrap = 1'b1;
            end else begin
                pv_next = PV + 9'd1;
            end
        end
    end

    always_comb begin
        hs_in = in_window(PH, hs_start, HSW10, HTOT10);
        vs_in = in_window(PV, vs_start, VSW10, VTOT10);
    end

    always_ff @(posedge MCLK) begin
        if (RESET) begin
            div     <= '0;
            PH      <= '0;
            PV      <= '0;
            HBLK    <= 1'b0;
            VBLK    <= 1'b0;
            FRAME   <= 1'b0;
            VID_RGB <= '0;
            VID_HB  <= 1'b1;
            VID_VB  <= 1'b1;
            VID_HS  <= 1'b0;
            VID_VS  <= 1'b0;
        end else begin
            FRAME <= 1'b0;
            if (PCLK_EN) begin
                div   <= '0;
                PH    <= ph_next;
                PV    <= pv_next;
                // Blanks follow the next counter values so they move with PH/PV.
                HBLK  <= (ph_next >= 9'(HVIS));
                VBLK  <= (pv_next >= 9'(VVIS));
                FRAME <= frame_wrap;
                // Output stage captures the pixel for the PH/PV now ending.
                VID_RGB <= (HBLK | VBLK) ? '0 : POUT;
                VID_HB  <= HBLK;
                VID_VB  <= VBLK;
                VID_HS  <= hs_in;
                VID_VS  <= vs_in;
            end else begin
                div <= div + DW'(1);
            end
        end
    end

endmodule

// File: tb/tb_digdug_hvgen.sv
module tb_digdug_hvgen;

    // Reduced raster so several whole frames fit in a short run; the sync
    // windows are placed to straddle the counter wrap on both axes.
    localparam int CLKDIV = 8;
    localparam int HT     = 40;
    localparam int HV     = 30;
    localparam int HSS    = 38;
    localparam int HSW    = 4;
    localparam int VT     = 12;
    localparam int VV     = 8;
    localparam int VSS    = 10;
    localparam int VSW    = 3;
    localparam int FRM    = HT * VT;

`ifdef SYNC_SHIFT_EN
    localparam bit SHIFT_ON = 1'b1;
`else
    localparam bit SHIFT_ON = 1'b0;
`endif

    logic       MCLK  = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] HOFS  = 4'h0;
    logic [3:0] VOFS  = 4'h0;
    logic [7:0] POUT  = 8'h00;
    logic       PCLK_EN;
    logic [8:0] PH;
    logic [8:0] PV;
    logic       HBLK;
    logic       VBLK;
    logic       FRAME;
    logic [7:0] VID_RGB;
    logic       VID_HB;
    logic       VID_VB;
    logic       VID_HS;
    logic       VID_VS;

    typedef struct packed {
        logic [7:0] rgb;
        logic       hb;
        logic       vb;
        logic       hs;
        logic       vs;
    } vid_t;

    vid_t sb_q[$];
    vid_t vid_exp;
    int   cyc;
    int   pix;
    int   n_assert;
    int   n_fail;
    bit   const_mode;

    digdug_hvgen #(
        .CLKDIV  (CLKDIV),
        .HTOTAL  (HT),
        .HVIS    (HV),
        .HS_START(HSS),
        .HS_WIDTH(HSW),
        .VTOTAL  (VT),
        .VVIS    (VV),
        .VS_START(VSS),
        .VS_WIDTH(VSW)
    ) dut (
        .MCLK   (MCLK),
        .RESET  (RESET),
        .HOFS   (HOFS),
        .VOFS   (VOFS),
        .POUT   (POUT),
        .PCLK_EN(PCLK_EN),
        .PH     (PH),
        .PV     (PV),
        .HBLK   (HBLK),
        .VBLK   (VBLK),
        .FRAME  (FRAME),
        .VID_RGB(VID_RGB),
        .VID_HB (VID_HB),
        .VID_VB (VID_VB),
        .VID_HS (VID_HS),
        .VID_VS (VID_VS)
    );

    always #5 MCLK = ~MCLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (cyc %0d pix %0d)", tag, obs, exp, cyc, pix);
        end
    endtask

    function automatic int sync_start(input int base, input int ofs, input int total);
        return ((base + ofs) % total + total) % total;
    endfunction

    function automatic bit in_win(input int pos, input int start, input int width, input int total);
        for (int unsigned k = 0; k < 32'(width); k++)
            if ((start + int'(k)) % total == pos)
                return 1'b1;
        return 1'b0;
    endfunction

    // Drive the pixel for the raster position now starting and push what the
    // output stage must show once that pixel ends.
    task automatic start_pixel();
        int   ph;
        int   pv;
        int   ho;
        int   vo;
        bit   hb;
        bit   vb;
        vid_t e;
        POUT = const_mode ? 8'hA5 : 8'($urandom);
        ph = pix % HT;
        pv = (pix / HT) % VT;
        ho = 0;
        vo = 0;
        if (SHIFT_ON && (pix / FRM) >= 1) begin
            ho = -4;
            vo = 3;
        end
        hb = (ph >= HV);
        vb = (pv >= VV);
        e.rgb = (hb || vb) ? 8'h00 : POUT;
        e.hb  = hb;
        e.vb  = vb;
        e.hs  = in_win(ph, sync_start(HSS, ho, HT), HSW, HT);
        e.vs  = in_win(pv, sync_start(VSS, vo, VT), VSW, VT);
        sb_q.push_back(e);
    endtask

    task automatic check_cycle();
        int d;
        int ph;
        int pv;
        d  = cyc % CLKDIV;
        ph = pix % HT;
        pv = (pix / HT) % VT;
        chk("pclk_en", 32'(PCLK_EN), 32'(d == CLKDIV - 1));
        chk("ph",      32'(PH),      32'(ph));
        chk("pv",      32'(PV),      32'(pv));
        chk("hblk",    32'(HBLK),    32'(ph >= HV));
        chk("vblk",    32'(VBLK),    32'(pv >= VV));
        chk("frame",   32'(FRAME),   32'(d == 0 && pix > 0 && pix % FRM == 0));
        if (d == 0 && pix > 0 && sb_q.size() > 0)
            vid_exp = sb_q.pop_front();
        chk("vid_rgb", 32'(VID_RGB), 32'(vid_exp.rgb));
        chk("vid_hb",  32'(VID_HB),  32'(vid_exp.hb));
        chk("vid_vb",  32'(VID_VB),  32'(vid_exp.vb));
        chk("vid_hs",  32'(VID_HS),  32'(vid_exp.hs));
        chk("vid_vs",  32'(VID_VS),  32'(vid_exp.vs));
        if (d == 0)
            start_pixel();
    endtask

    task automatic cycle();
        @(posedge MCLK);
        cyc++;
        if (cyc % CLKDIV == 0)
            pix++;
        @(negedge MCLK);
        check_cycle();
    endtask

    task automatic apply_reset(input int n);
        RESET = 1'b1;
        repeat (n) begin
            @(posedge MCLK);
            @(negedge MCLK);
            chk("rst_pclk_en", 32'(PCLK_EN), 32'd0);
            chk("rst_ph",      32'(PH),      32'd0);
            chk("rst_pv",      32'(PV),      32'd0);
            chk("rst_hblk",    32'(HBLK),    32'd0);
            chk("rst_vblk",    32'(VBLK),    32'd0);
            chk("rst_frame",   32'(FRAME),   32'd0);
            chk("rst_vid_rgb", 32'(VID_RGB), 32'd0);
            chk("rst_vid_hb",  32'(VID_HB),  32'd1);
            chk("rst_vid_vb",  32'(VID_VB),  32'd1);
            chk("rst_vid_hs",  32'(VID_HS),  32'd0);
            chk("rst_vid_vs",  32'(VID_VS),  32'd0);
        end
        RESET   = 1'b0;
        cyc     = 0;
        pix     = 0;
        sb_q.delete();
        vid_exp = '{rgb: 8'h00, hb: 1'b1, vb: 1'b1, hs: 1'b0, vs: 1'b0};
        start_pixel();
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        const_mode = 1'b1;

        // Power-up reset, then a frame of constant A5 pixels.
        apply_reset(3);
        repeat (100 * CLKDIV) cycle();

        // Sync offsets changed mid-frame; they may only take effect next frame.
        HOFS = 4'hC;
        VOFS = 4'h3;
        repeat ((FRM - 100) * CLKDIV) cycle();

        // Second frame with random pixel data.
        const_mode = 1'b0;
        repeat (FRM * CLKDIV) cycle();

        // Reset in the middle of a frame at PH=15, PV=5, then restart.
        repeat ((5 * HT + 15) * CLKDIV) cycle();
        apply_reset(2);
        repeat ((2 * HT) * CLKDIV + 5) cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
